// File: rtl/matmul_sequencer.sv
// Control sequencer for C = A*B on one shared FP multiplier and one shared FP adder.
// Latency: M*M*(4M+2) cycles per run with zero-stall units; start transfer to first z_we is 4M+2 cycles.
// Backpressure: every stage waits on its stb/ack pair; stalls only stretch the current state.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start_stb / start_ack     run request handshake (ack high only while idle)
//   idx_i, idx_j, idx_k       operand indices: A[i][k], B[k][j], result C[i][j]
//   mul_in_stb / mul_in_ack   multiplier operand handshake
//   mul_z_stb / mul_z_ack     multiplier result handshake; prod_we marks the product transfer
//   add_in_stb / add_in_ack   adder operand handshake (acc, prod)
//   add_z_stb / add_z_ack     adder result handshake; acc_we marks the sum transfer
//   acc_clr, z_we             accumulator clear, result write of acc into C[i][j]
//   done_stb / done_ack       run completion handshake
//   busy                      high whenever a run is in progress or awaiting done_ack
module matmul_sequencer #(
    parameter int M  = 4,
    parameter int IW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stb,
    output logic          start_ack,
    output logic [IW-1:0] idx_i,
    output logic [IW-1:0] idx_j,
    output logic [IW-1:0] idx_k,
    output logic          mul_in_stb,
    input  logic          mul_in_ack,
    input  logic          mul_z_stb,
    output logic          mul_z_ack,
    output logic          prod_we,
    output logic          add_in_stb,
    input  logic          add_in_ack,
    input  logic          add_z_stb,
    output logic          add_z_ack,
    output logic          acc_clr,
    output logic          acc_we,
    output logic          z_we,
    output logic          done_stb,
    input  logic          done_ack,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MUL_IN,
        S_MUL_OUT,
        S_ADD_IN,
        S_ADD_OUT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(M - 1);

    state_t        state_q, state_n;
    logic [IW-1:0] i_q, j_q, k_q;
    logic [IW-1:0] i_n, j_n, k_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_n;
            i_q     <= i_n;
            j_q     <= j_n;
            k_q     <= k_n;
        end
    end

    always_comb begin
        state_n = state_q;
        i_n     = i_q;
        j_n     = j_q;
        k_n     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_stb) begin
                    state_n = S_CLR;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            S_CLR:     state_n = S_MUL_IN;
            S_MUL_IN:  if (mul_in_ack) state_n = S_MUL_OUT;
            S_MUL_OUT: if (mul_z_stb)  state_n = S_ADD_IN;
            S_ADD_IN:  if (add_in_ack) state_n = S_ADD_OUT;
            S_ADD_OUT: begin
                if (add_z_stb) begin
                    if (k_q == LAST) begin
                        state_n = S_WRITE;
                    end else begin
                        k_n     = k_q + 1'b1;
                        state_n = S_MUL_IN;
                    end
                end
            end
            S_WRITE: begin
                // Row-major walk: j is the fast index; the last element leaves
                // i at M-1 and j at 0 while the block sits in DONE.
                k_n     = '0;
                state_n = S_CLR;
                if (j_q != LAST) begin
                    j_n = j_q + 1'b1;
                end else begin
                    j_n = '0;
                    if (i_q != LAST) begin
                        i_n = i_q + 1'b1;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  if (done_ack) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign start_ack  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign idx_i      = i_q;
    assign idx_j      = j_q;
    assign idx_k      = k_q;
    assign acc_clr    = (state_q == S_CLR);
    assign mul_in_stb = (state_q == S_MUL_IN);
    assign mul_z_ack  = (state_q == S_MUL_OUT);
    assign add_in_stb = (state_q == S_ADD_IN);
    assign add_z_ack  = (state_q == S_ADD_OUT);
    assign z_we       = (state_q == S_WRITE);
    assign done_stb   = (state_q == S_DONE);

    // The unit's result is only guaranteed valid up to its transfer edge, so
    // the latch pulses are qualified by the result strobe: they fire exactly on
    // the transfer cycle, however long the unit stalls.
    assign prod_we    = mul_z_ack & mul_z_stb;
    assign acc_we     = add_z_ack & add_z_stb;

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;
    localparam int M  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // M=4 instance
    logic start_stb, start_ack, mul_in_stb, mul_in_ack, mul_z_stb, mul_z_ack, prod_we;
    logic add_in_stb, add_in_ack, add_z_stb, add_z_ack, acc_clr, acc_we, z_we;
    logic done_stb, done_ack, busy;
    logic [IW-1:0] idx_i, idx_j, idx_k;

    // M=2 instance
    logic start_stb2, start_ack2, mul_in_stb2, mul_in_ack2, mul_z_stb2, mul_z_ack2, prod_we2;
    logic add_in_stb2, add_in_ack2, add_z_stb2, add_z_ack2, acc_clr2, acc_we2, z_we2;
    logic done_stb2, done_ack2, busy2;
    logic [0:0] idx_i2, idx_j2, idx_k2;

    matmul_sequencer #(.M(4), .IW(2)) u_dut (
        .clk(clk), .rst(rst), .start_stb(start_stb), .start_ack(start_ack),
        .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
        .mul_in_stb(mul_in_stb), .mul_in_ack(mul_in_ack), .mul_z_stb(mul_z_stb),
        .mul_z_ack(mul_z_ack), .prod_we(prod_we),
        .add_in_stb(add_in_stb), .add_in_ack(add_in_ack), .add_z_stb(add_z_stb),
        .add_z_ack(add_z_ack), .acc_clr(acc_clr), .acc_we(acc_we), .z_we(z_we),
        .done_stb(done_stb), .done_ack(done_ack), .busy(busy)
    );

    matmul_sequencer #(.M(2), .IW(1)) u_dut2 (
        .clk(clk), .rst(rst), .start_stb(start_stb2), .start_ack(start_ack2),
        .idx_i(idx_i2), .idx_j(idx_j2), .idx_k(idx_k2),
        .mul_in_stb(mul_in_stb2), .mul_in_ack(mul_in_ack2), .mul_z_stb(mul_z_stb2),
        .mul_z_ack(mul_z_ack2), .prod_we(prod_we2),
        .add_in_stb(add_in_stb2), .add_in_ack(add_in_ack2), .add_z_stb(add_z_stb2),
        .add_z_ack(add_z_ack2), .acc_clr(acc_clr2), .acc_we(acc_we2), .z_we(z_we2),
        .done_stb(done_stb2), .done_ack(done_ack2), .busy(busy2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Datapath and unit models for the M=4 instance
    real a_m [0:M-1][0:M-1];
    real b_m [0:M-1][0:M-1];
    real c_m [0:M-1][0:M-1];
    real acc, prod, mul_res, add_res;
    bit  mul_pend, add_pend, stall_en, stray_en;
    int  mul_cnt, add_cnt, mi_w, ai_w;
    bit  p_mul_in_x, p_mul_z_x, p_add_in_x, p_add_z_x, p_prod_we, p_acc_we, p_acc_clr, p_z_we;
    bit  p_start_x, p_done_x, p_mul_in_stb, p_add_in_stb, p_done_stb, p_rst;
    logic [IW-1:0] p_i, p_j, p_k;
    int  cyc = 0, start_cyc, first_zw_cyc, done_cyc, zw_cnt, n_start, n_done;

    // Datapath and unit models for the M=2 instance (zero-stall units)
    real a2 [0:1][0:1];
    real b2 [0:1][0:1];
    real c2 [0:1][0:1];
    real acc2, prod2, mres2, ares2;
    bit  mpend2, apend2;
    bit  q_mi, q_mz, q_ai, q_az, q_prod, q_accwe, q_clr, q_zwe, q_start, q_done;
    logic [0:0] q_i, q_j, q_k;
    int  start2_cyc, done2_cyc, n_start2, n_done2;

    function automatic int st();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    task automatic reset_models();
        mul_pend = 0; add_pend = 0; mul_cnt = 0; add_cnt = 0; mi_w = 0; ai_w = 0;
        mul_in_ack = 0; mul_z_stb = 0; add_in_ack = 0; add_z_stb = 0;
        mpend2 = 0; apend2 = 0;
        mul_in_ack2 = 0; mul_z_stb2 = 0; add_in_ack2 = 0; add_z_stb2 = 0;
        acc = 0.0; prod = 0.0; acc2 = 0.0; prod2 = 0.0;
    endtask

    // One clock cycle: capture the handshakes that will transfer at the next
    // edge, advance, then apply those transfers and drive the units.
    task automatic step();
        #1;
        p_mul_in_x = mul_in_stb && mul_in_ack;
        p_mul_z_x  = mul_z_stb && mul_z_ack;
        p_add_in_x = add_in_stb && add_in_ack;
        p_add_z_x  = add_z_stb && add_z_ack;
        p_prod_we = prod_we; p_acc_we = acc_we; p_acc_clr = acc_clr; p_z_we = z_we;
        p_start_x = start_stb && start_ack;
        p_done_x  = done_stb && done_ack;
        p_mul_in_stb = mul_in_stb; p_add_in_stb = add_in_stb; p_done_stb = done_stb;
        p_i = idx_i; p_j = idx_j; p_k = idx_k; p_rst = rst;
        q_mi = mul_in_stb2 && mul_in_ack2; q_mz = mul_z_stb2 && mul_z_ack2;
        q_ai = add_in_stb2 && add_in_ack2; q_az = add_z_stb2 && add_z_ack2;
        q_prod = prod_we2; q_accwe = acc_we2; q_clr = acc_clr2; q_zwe = z_we2;
        q_start = start_stb2 && start_ack2; q_done = done_stb2 && done_ack2;
        q_i = idx_i2; q_j = idx_j2; q_k = idx_k2;
        if (!rst) begin
            check("prod_we", 64'(prod_we), 64'(p_mul_z_x));
            check("acc_we", 64'(acc_we), 64'(p_add_z_x));
            check("start_ack_idle", 64'(start_ack), 64'(!busy));
            if (z_we) begin
                check("zwe_i", 64'(idx_i), 64'(zw_cnt / M));
                check("zwe_j", 64'(idx_j), 64'(zw_cnt % M));
                if (zw_cnt == 0) first_zw_cyc = cyc - start_cyc;
                zw_cnt++;
            end
            if (done_stb && done_cyc < 0) done_cyc = cyc - start_cyc;
            if (done_stb2 && done2_cyc < 0) done2_cyc = cyc - start2_cyc;
            check("prod_we2", 64'(prod_we2), 64'(q_mz));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (p_start_x) begin n_start++; start_cyc = cyc - 1; end
        if (p_done_x) n_done++;
        if (q_start) begin n_start2++; start2_cyc = cyc - 1; end
        if (q_done) n_done2++;
        if (!rst && !p_rst) begin
            if (p_mul_in_stb && !p_mul_in_x) check("mul_in_stb_hold", 64'(mul_in_stb), 64'd1);
            if (p_add_in_stb && !p_add_in_x) check("add_in_stb_hold", 64'(add_in_stb), 64'd1);
            if (p_done_stb && !p_done_x) check("done_stb_hold", 64'(done_stb), 64'd1);
        end
        // M=4 datapath
        if (p_mul_in_x) begin
            mul_res = a_m[p_i][p_k] * b_m[p_k][p_j];
            mul_pend = 1; mul_cnt = st(); mi_w = st();
        end
        if (p_mul_z_x) mul_pend = 0;
        if (p_prod_we) prod = mul_res;
        if (p_add_in_x) begin
            add_res = acc + prod;
            add_pend = 1; add_cnt = st(); ai_w = st();
        end
        if (p_add_z_x) add_pend = 0;
        if (p_z_we) c_m[p_i][p_j] = acc;
        if (p_acc_clr) acc = 0.0;
        if (p_acc_we) acc = add_res;
        // M=4 units: ack after a random wait; result some cycles after acceptance
        if (mul_in_stb) begin
            if (mi_w == 0) mul_in_ack = 1; else begin mul_in_ack = 0; mi_w--; end
        end else mul_in_ack = stray_en && ($urandom_range(0, 3) == 0);
        if (mul_pend) begin
            if (mul_cnt == 0) mul_z_stb = 1; else begin mul_z_stb = 0; mul_cnt--; end
        end else mul_z_stb = stray_en && !mul_z_ack && ($urandom_range(0, 3) == 0);
        if (add_in_stb) begin
            if (ai_w == 0) add_in_ack = 1; else begin add_in_ack = 0; ai_w--; end
        end else add_in_ack = stray_en && ($urandom_range(0, 3) == 0);
        if (add_pend) begin
            if (add_cnt == 0) add_z_stb = 1; else begin add_z_stb = 0; add_cnt--; end
        end else add_z_stb = stray_en && !add_z_ack && ($urandom_range(0, 3) == 0);
        // M=2 datapath and zero-stall units
        if (q_mi) begin mres2 = a2[q_i][q_k] * b2[q_k][q_j]; mpend2 = 1; end
        if (q_mz) mpend2 = 0;
        if (q_prod) prod2 = mres2;
        if (q_ai) begin ares2 = acc2 + prod2; apend2 = 1; end
        if (q_az) apend2 = 0;
        if (q_zwe) c2[q_i][q_j] = acc2;
        if (q_clr) acc2 = 0.0;
        if (q_accwe) acc2 = ares2;
        mul_in_ack2 = mul_in_stb2; mul_z_stb2 = mpend2;
        add_in_ack2 = add_in_stb2; add_z_stb2 = apend2;
    endtask

    task automatic do_start();
        int t = 0;
        zw_cnt = 0; first_zw_cyc = -1; done_cyc = -1; n_start = 0; n_done = 0;
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) c_m[i][j] = 999.0;
        start_stb = 1;
        while (n_start == 0 && t < 100) begin step(); t++; end
        start_stb = 0;
        check("start_taken", 64'(n_start), 64'd1);
    endtask

    task automatic finish_run(input int done_hold, input bit timing);
        int t = 0;
        while (!done_stb && t < 20000) begin
            if (stray_en) begin
                start_stb = 1'($urandom_range(0, 1));
                done_ack  = 1'($urandom_range(0, 1));
            end
            step(); t++;
        end
        start_stb = 0; done_ack = 0;
        check("done_reached", 64'(done_stb), 64'd1);
        for (int h = 0; h < done_hold; h++) begin
            if (stray_en) start_stb = 1'($urandom_range(0, 1));
            step();
        end
        start_stb = 0;
        check("done_still_high", 64'(done_stb), 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        done_ack = 1; t = 0;
        while (n_done == 0 && t < 100) begin step(); t++; end
        done_ack = 0;
        check("done_taken", 64'(n_done), 64'd1);
        check("start_ack_after_done", 64'(start_ack), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("start_count", 64'(n_start), 64'd1);
        check("zwe_count", 64'(zw_cnt), 64'(M * M));
        if (timing) begin
            check("first_zwe_cycle", 64'(first_zw_cyc), 64'd18);
            check("done_cycle", 64'(done_cyc), 64'd289);
        end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                real r = 0.0;
                for (int k = 0; k < M; k++) r = r + a_m[i][k] * b_m[k][j];
                check($sformatf("C[%0d][%0d]", i, j), $realtobits(c_m[i][j]), $realtobits(r));
            end
        end
    endtask

    task automatic randomize_ab();
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                int va = int'($urandom_range(0, 64)) - 32;
                int vb = int'($urandom_range(0, 64)) - 32;
                a_m[i][j] = real'(va) / 3.0;
                b_m[i][j] = real'(vb) / 7.0;
            end
        end
    endtask

    task automatic run2();
        int t = 0;
        n_start2 = 0; n_done2 = 0; done2_cyc = -1;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) c2[i][j] = 999.0;
        start_stb2 = 1;
        while (n_start2 == 0 && t < 100) begin step(); t++; end
        start_stb2 = 0;
        t = 0;
        while (!done_stb2 && t < 1000) begin step(); t++; end
        check("m2_done_reached", 64'(done_stb2), 64'd1);
        done_ack2 = 1; t = 0;
        while (n_done2 == 0 && t < 100) begin step(); t++; end
        done_ack2 = 0;
        check("m2_start_ack_after_done", 64'(start_ack2), 64'd1);
    endtask

    initial begin
        start_stb = 0; done_ack = 0; start_stb2 = 0; done_ack2 = 0;
        stall_en = 0; stray_en = 0;
        reset_models();
        #1 rst = 1;
        #2;
        check("rst_start_ack", 64'(start_ack), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_idx", 64'({idx_i, idx_j, idx_k}), 64'd0);
        check("rst_strobes", 64'({mul_in_stb, mul_z_ack, prod_we, add_in_stb, add_z_ack,
                                  acc_clr, acc_we, z_we, done_stb}), 64'd0);
        check("rst_start_ack2", 64'(start_ack2), 64'd1);
        #9 rst = 0;

        // Identity times B, zero-stall units
        for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) a_m[i][j] = (i == j) ? 1.0 : 0.0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) b_m[i][j] = real'(i * M + j + 1) * 1.5;
        do_start();
        finish_run(0, 1);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                check($sformatf("ident_C[%0d][%0d]", i, j), $realtobits(c_m[i][j]), $realtobits(b_m[i][j]));

        // Random matrices, random stalls, stray handshakes, done_ack held off 20 cycles
        stall_en = 1; stray_en = 1;
        randomize_ab();
        do_start();
        finish_run(20, 0);

        // Asynchronous reset in ADD_IN at element (2,1), k=2
        stall_en = 0; stray_en = 0;
        randomize_ab();
        do_start();
        begin
            int t = 0;
            while (!(add_in_stb && idx_i == 2'd2 && idx_j == 2'd1 && idx_k == 2'd2) && t < 1000) begin
                step(); t++;
            end
        end
        check("reached_add_in_2_1_2", 64'(add_in_stb), 64'd1);
        #2 rst = 1;
        #1;
        check("midrst_start_ack", 64'(start_ack), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_idx", 64'({idx_i, idx_j, idx_k}), 64'd0);
        check("midrst_strobes", 64'({mul_in_stb, mul_z_ack, prod_we, add_in_stb, add_z_ack,
                                     acc_clr, acc_we, z_we, done_stb}), 64'd0);
        reset_models();
        step(); step();
        rst = 0;
        stall_en = 1;
        randomize_ab();
        do_start();
        finish_run(0, 0);

        // M=2 instance
        a2[0][0] = 1.0; a2[0][1] = 2.0; a2[1][0] = 3.0; a2[1][1] = 4.0;
        b2[0][0] = 5.0; b2[0][1] = 6.0; b2[1][0] = 7.0; b2[1][1] = 8.0;
        run2();
        check("m2_C00", $realtobits(c2[0][0]), $realtobits(19.0));
        check("m2_C01", $realtobits(c2[0][1]), $realtobits(22.0));
        check("m2_C10", $realtobits(c2[1][0]), $realtobits(43.0));
        check("m2_C11", $realtobits(c2[1][1]), $realtobits(50.0));
        check("m2_done_cycle", 64'(done2_cyc), 64'd41);

        // Negative-zero product folds into a +0.0 accumulator
        a2[0][0] = -1.0; a2[0][1] = 0.0; a2[1][0] = 2.0; a2[1][1] = 3.0;
        b2[0][0] = 0.0;  b2[0][1] = 1.0; b2[1][0] = 0.0; b2[1][1] = 2.0;
        run2();
        check("negzero_C00", $realtobits(c2[0][0]), 64'd0);
        check("negzero_C11", $realtobits(c2[1][1]), $realtobits(8.0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
